// File: rtl/nco_wb_master_if.sv
// -----------------------------------------------------------------------------
// nco_wb_master_if
//   Wishbone classic bus bundle between the NCO sweep initiator and the NCO
//   register slave.
//
//   Signals (names seen from the initiator side):
//     wb_cyc_o  bus cycle in progress
//     wb_stb_o  strobe (always equal to wb_cyc_o for this initiator)
//     wb_we_o   1 = write, 0 = read
//     wb_adr_o  byte address
//     wb_dat_o  write data
//     wb_sel_o  byte lane select
//     wb_ack_i  responder acknowledge
//     wb_dat_i  responder read data
//
//   Modports:
//     master  initiator view (drives cyc/stb/we/adr/dat/sel)
//     slave   responder view (drives ack and read data)
// -----------------------------------------------------------------------------
interface nco_wb_master_if;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;

   modport master (
      output wb_cyc_o,
      output wb_stb_o,
      output wb_we_o,
      output wb_adr_o,
      output wb_dat_o,
      output wb_sel_o,
      input  wb_ack_i,
      input  wb_dat_i
   );

   modport slave (
      input  wb_cyc_o,
      input  wb_stb_o,
      input  wb_we_o,
      input  wb_adr_o,
      input  wb_dat_o,
      input  wb_sel_o,
      output wb_ack_i,
      output wb_dat_i
   );
endinterface

// File: rtl/nco_wb_master.sv
// -----------------------------------------------------------------------------
// nco_wb_master
//   Wishbone classic initiator that sweeps the NCO register slave. A 32-bit
//   phase accumulator is written to the angle register; after a settle delay
//   that covers the NCO pipeline the x/y register is read back, and the
//   (angle, xy) pair is delivered on a valid/ready stream. The accumulator then
//   advances by phase_step and the next sample starts while enable is high.
//
//   Ports:
//     clk           single clock
//     reset         asynchronous, active-high reset; all outputs return to 0
//     enable        run the sweep while high (a started sample always finishes)
//     phase_step    accumulator increment, sampled on the read acknowledge
//     phase_clr     zero the accumulator; only acted on while idle
//     clear_err     clear the sticky timeout flag
//     sample_valid  sample_angle / sample_xy hold a sample
//     sample_ready  consumer accepts the sample
//     sample_angle  phase that was written for this sample
//     sample_xy     data returned by the x/y read
//     busy          high whenever the sequencer is not idle
//     err_timeout   sticky: a bus transaction was aborted for lack of ACK
//     wb            Wishbone initiator port (master modport)
//
//   Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module nco_wb_master #(
   parameter logic [31:0] ANGLE_ADDR    = 32'h3000_0000,
   parameter logic [31:0] XY_ADDR       = 32'h3000_0004,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [31:0]     phase_step,
   input  logic            phase_clr,
   input  logic            clear_err,
   output logic            sample_valid,
   input  logic            sample_ready,
   output logic [31:0]     sample_angle,
   output logic [31:0]     sample_xy,
   output logic            busy,
   output logic            err_timeout,
   nco_wb_master_if.master wb
);

   // With SETTLE_CYCLES = 0 the sequencer still spends one cycle with cyc low
   // between the write and the read, so strobes are never back to back.
   localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int unsigned ST_W       = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam int unsigned TO_W       = $clog2(TIMEOUT + 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_EFF - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_SETTLE,
      S_RD,
      S_OUT
   } state_t;

   state_t          state_q,  state_d;
   logic [31:0]     phase_q,  phase_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [ST_W-1:0] settle_q, settle_d;
   logic            cyc_q,    cyc_d;
   logic            we_q,     we_d;
   logic [31:0]     adr_q,    adr_d;
   logic [31:0]     dat_q,    dat_d;
   logic [3:0]      sel_q,    sel_d;
   logic            valid_q,  valid_d;
   logic [31:0]     angle_q,  angle_d;
   logic [31:0]     xy_q,     xy_d;
   logic            busy_q,   busy_d;
   logic            err_q,    err_d;
   logic            abort;

   // ---------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      to_cnt_d = to_cnt_q;
      settle_d = settle_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      valid_d  = valid_q;
      angle_d  = angle_q;
      xy_d     = xy_q;
      err_d    = err_q;
      abort    = 1'b0;

      if (clear_err) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            // Clearing the accumulator takes the cycle; the sweep starts on
            // the following one if enable is still high.
            if (phase_clr) begin
               phase_d = '0;
            end else if (enable) begin
               state_d  = S_WR;
               cyc_d    = 1'b1;
               we_d     = 1'b1;
               adr_d    = ANGLE_ADDR;
               dat_d    = phase_q;
               to_cnt_d = '0;
            end
         end

         S_WR: begin
            if (wb.wb_ack_i) begin
               state_d  = S_SETTLE;
               settle_d = '0;
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               adr_d    = '0;
               dat_d    = '0;
            end else if (to_cnt_q == TO_LAST) begin
               abort = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

         S_SETTLE: begin
            if (settle_q == ST_LAST) begin
               state_d  = S_RD;
               cyc_d    = 1'b1;
               we_d     = 1'b0;
               adr_d    = XY_ADDR;
               dat_d    = '0;
               to_cnt_d = '0;
            end else begin
               settle_d = settle_q + ST_W'(1);
            end
         end

         S_RD: begin
            if (wb.wb_ack_i) begin
               state_d = S_OUT;
               xy_d    = wb.wb_dat_i;
               angle_d = phase_q;
               phase_d = phase_q + phase_step;
               valid_d = 1'b1;
               cyc_d   = 1'b0;
               adr_d   = '0;
            end else if (to_cnt_q == TO_LAST) begin
               abort = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

         S_OUT: begin
            // The bus stays quiet while the sample waits for the consumer.
            if (sample_ready) begin
               valid_d = 1'b0;
               if (enable) begin
                  state_d  = S_WR;
                  cyc_d    = 1'b1;
                  we_d     = 1'b1;
                  adr_d    = ANGLE_ADDR;
                  dat_d    = phase_q;
                  to_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            valid_d = 1'b0;
         end
      endcase

      // Timeout: abandon the transaction without touching phase or the
      // sample registers. Setting the flag overrides a same-cycle clear.
      if (abort) begin
         state_d = S_IDLE;
         cyc_d   = 1'b0;
         we_d    = 1'b0;
         adr_d   = '0;
         dat_d   = '0;
         err_d   = 1'b1;
      end

      sel_d  = cyc_d ? 4'hF : 4'h0;
      busy_d = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         to_cnt_q <= '0;
         settle_q <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         angle_q  <= '0;
         xy_q     <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         to_cnt_q <= to_cnt_d;
         settle_q <= settle_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         angle_q  <= angle_d;
         xy_q     <= xy_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign wb.wb_cyc_o  = cyc_q;
   assign wb.wb_stb_o  = cyc_q;
   assign wb.wb_we_o   = we_q;
   assign wb.wb_adr_o  = adr_q;
   assign wb.wb_dat_o  = dat_q;
   assign wb.wb_sel_o  = sel_q;

   assign sample_valid = valid_q;
   assign sample_angle = angle_q;
   assign sample_xy    = xy_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;

endmodule
